// File: rtl/lock_ctrl.sv
// Keypad lock controller: collects four BCD digits, checks them against a stored PIN,
// times the unlock window and enforces an alarm lockout after repeated failures.
module lock_ctrl #(
   parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
   parameter int unsigned MAX_TRIES      = 3,
   parameter logic [15:0] UNLOCK_CYCLES  = 16'd100,
   parameter logic [15:0] LOCKOUT_CYCLES = 16'd1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] digit,
   input  logic       digit_valid,
   input  logic       enter,
   input  logic       clear,
   input  logic       prog_en,
   output logic       access,
   output logic       alarm,
   output logic       locked_out,
   output logic [2:0] tries_left,
   output logic [2:0] digit_cnt
);

   localparam logic [2:0] MaxTries = 3'(MAX_TRIES);

   typedef enum logic [1:0] {StIdle, StCheck, StUnlocked, StLockout} state_t;

   state_t      state;
   logic [15:0] pin_reg;
   logic [15:0] code_buf;
   logic [2:0]  fail_cnt;
   logic [15:0] timer;

   logic key_ok;
   logic match;
   logic prog_ok;

   assign key_ok  = digit_valid && (digit <= 4'd9) && (digit_cnt < 3'd4);
   assign match   = (digit_cnt == 3'd4) && (code_buf == pin_reg);
   assign prog_ok = prog_en && (digit_cnt == 3'd4);

   // fail_cnt sits at MaxTries only while locked out, so tries_left reads 0 there
   assign tries_left = MaxTries - fail_cnt;
   assign locked_out = alarm;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= StIdle;
         pin_reg   <= DEFAULT_PIN;
         code_buf  <= 16'h0000;
         digit_cnt <= 3'd0;
         fail_cnt  <= 3'd0;
         timer     <= 16'd0;
         access    <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (clear) begin
                  code_buf  <= 16'h0000;
                  digit_cnt <= 3'd0;
               end else if (enter) begin
                  state <= StCheck;
               end else if (key_ok) begin
                  code_buf  <= {code_buf[11:0], digit};
                  digit_cnt <= digit_cnt + 3'd1;
               end
            end

            StCheck: begin
               code_buf  <= 16'h0000;
               digit_cnt <= 3'd0;
               if (match) begin
                  state    <= StUnlocked;
                  fail_cnt <= 3'd0;
                  timer    <= UNLOCK_CYCLES - 16'd1;
                  access   <= 1'b1;
               end else if (fail_cnt + 3'd1 == MaxTries) begin
                  state    <= StLockout;
                  fail_cnt <= MaxTries;
                  timer    <= LOCKOUT_CYCLES - 16'd1;
                  alarm    <= 1'b1;
               end else begin
                  state    <= StIdle;
                  fail_cnt <= fail_cnt + 3'd1;
               end
            end

            StUnlocked: begin
               if (timer == 16'd0) begin
                  // window expiry wins over any keypad activity in the same cycle
                  state     <= StIdle;
                  access    <= 1'b0;
                  code_buf  <= 16'h0000;
                  digit_cnt <= 3'd0;
               end else begin
                  timer <= timer - 16'd1;
                  if (clear) begin
                     code_buf  <= 16'h0000;
                     digit_cnt <= 3'd0;
                  end else if (enter) begin
                     code_buf  <= 16'h0000;
                     digit_cnt <= 3'd0;
                     if (prog_ok) begin
                        pin_reg <= code_buf;
                        access  <= 1'b0;
                        state   <= StIdle;
                     end
                  end else if (key_ok) begin
                     code_buf  <= {code_buf[11:0], digit};
                     digit_cnt <= digit_cnt + 3'd1;
                  end
               end
            end

            StLockout: begin
               if (timer == 16'd0) begin
                  state    <= StIdle;
                  fail_cnt <= 3'd0;
                  alarm    <= 1'b0;
               end else begin
                  timer <= timer - 16'd1;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed vector bench for lock_ctrl: a per-cycle table of keypad inputs and expected
// outputs, plus hand-written sequences for the timed windows and asynchronous reset.
module tb_lock_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] digit;
   logic       digit_valid;
   logic       enter;
   logic       clear;
   logic       prog_en;
   logic       access;
   logic       alarm;
   logic       locked_out;
   logic [2:0] tries_left;
   logic [2:0] digit_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   lock_ctrl #(
      .DEFAULT_PIN   (16'h1234),
      .MAX_TRIES     (3),
      .UNLOCK_CYCLES (16'd100),
      .LOCKOUT_CYCLES(16'd1000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .digit      (digit),
      .digit_valid(digit_valid),
      .enter      (enter),
      .clear      (clear),
      .prog_en    (prog_en),
      .access     (access),
      .alarm      (alarm),
      .locked_out (locked_out),
      .tries_left (tries_left),
      .digit_cnt  (digit_cnt)
   );

   typedef struct {
      logic [3:0] dig;
      logic       dv;
      logic       en;
      logic       cl;
      logic       pr;
      logic       acc;
      logic       alm;
      logic [2:0] tl;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl[0:255];
   int   nrows = 0;

   task automatic add(input logic [3:0] dig, input logic dv, input logic en, input logic cl,
                      input logic pr, input logic acc, input logic alm, input logic [2:0] tl,
                      input logic [2:0] cnt);
      tbl[nrows] = '{dig, dv, en, cl, pr, acc, alm, tl, cnt};
      nrows++;
   endtask

   task automatic key(input logic [3:0] d, input logic acc, input logic [2:0] tl,
                      input logic [2:0] cnt);
      add(d, 1'b1, 1'b0, 1'b0, 1'b0, acc, 1'b0, tl, cnt);
   endtask

   task automatic idle(input logic acc, input logic alm, input logic [2:0] tl,
                       input logic [2:0] cnt);
      add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc, alm, tl, cnt);
   endtask

   task automatic push(input logic [3:0] d, input logic en, input logic acc,
                       input logic [2:0] tl, input logic [2:0] cnt);
      add(d, 1'b0, en, 1'b0, 1'b0, acc, 1'b0, tl, cnt);
   endtask

   // four keys, then enter, then the CHECK cycle
   task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [2:0] tl_in, input logic acc_out,
                        input logic alm_out, input logic [2:0] tl_out);
      key(a, 1'b0, tl_in, 3'd1);
      key(b, 1'b0, tl_in, 3'd2);
      key(c, 1'b0, tl_in, 3'd3);
      key(d, 1'b0, tl_in, 3'd4);
      push(4'd0, 1'b1, 1'b0, tl_in, 3'd4);
      idle(acc_out, alm_out, tl_out, 3'd0);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      digit = 4'd0; digit_valid = 1'b0; enter = 1'b0; clear = 1'b0; prog_en = 1'b0;
   endtask

   // called at a negedge; each row is one clock edge, checked on the following negedge
   task automatic run(input string tag, input int lo, input int hi);
      logic [8:0] got;
      logic [8:0] want;
      for (int i = lo; i < hi; i++) begin
         digit = tbl[i].dig; digit_valid = tbl[i].dv; enter = tbl[i].en;
         clear = tbl[i].cl;  prog_en = tbl[i].pr;
         @(posedge clk);
         @(negedge clk);
         got  = {access, alarm, locked_out, tries_left, digit_cnt};
         want = {tbl[i].acc, tbl[i].alm, tbl[i].alm, tbl[i].tl, tbl[i].cnt};
         nvec++;
         if (got !== want) begin
            nerr++;
            $display("FAIL %s row %0d: acc/alm/lo/tl/cnt got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                     tag, i - lo, got[8], got[7], got[6], got[5:3], got[2:0],
                     want[8], want[7], want[6], want[5:3], want[2:0]);
         end
      end
      drive_idle();
   endtask

   task automatic wait_access_low(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!access) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1;
      check("rst_access", 16'(access), 16'd0);
      check("rst_alarm", 16'(alarm), 16'd0);
      check("rst_locked_out", 16'(locked_out), 16'd0);
      check("rst_tries_left", 16'(tries_left), 16'd3);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   int s1, s2, s3, s4, s5, s6, s7;
   int n;
   int bad;
   logic ok;

   initial begin
      // T1: unlock with default PIN
      s1 = nrows;
      code4(4'd1, 4'd2, 4'd3, 4'd4, 3'd3, 1'b1, 1'b0, 3'd3);
      // T3 + T4: junk digit, dropped fifth digit, then reprogram while unlocked
      s2 = nrows;
      key(4'd1, 1'b0, 3'd3, 3'd1);
      key(4'd12, 1'b0, 3'd3, 3'd1);
      key(4'd2, 1'b0, 3'd3, 3'd2);
      key(4'd3, 1'b0, 3'd3, 3'd3);
      key(4'd4, 1'b0, 3'd3, 3'd4);
      key(4'd9, 1'b0, 3'd3, 3'd4);
      push(4'd0, 1'b1, 1'b0, 3'd3, 3'd4);
      idle(1'b1, 1'b0, 3'd3, 3'd0);
      key(4'd9, 1'b1, 3'd3, 3'd1);
      key(4'd8, 1'b1, 3'd3, 3'd2);
      key(4'd7, 1'b1, 3'd3, 3'd3);
      key(4'd6, 1'b1, 3'd3, 3'd4);
      add(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0);
      code4(4'd1, 4'd2, 4'd3, 4'd4, 3'd3, 1'b0, 1'b0, 3'd2);
      code4(4'd9, 4'd8, 4'd7, 4'd6, 3'd2, 1'b1, 1'b0, 3'd3);
      key(4'd5, 1'b1, 3'd3, 3'd1);
      push(4'd0, 1'b1, 1'b1, 3'd3, 3'd0);
      key(4'd1, 1'b1, 3'd3, 3'd1);
      key(4'd2, 1'b1, 3'd3, 3'd2);
      add(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0);
      // T3 short code, T5 same-cycle priority, then restore PIN 1234
      s3 = nrows;
      key(4'd1, 1'b0, 3'd3, 3'd1);
      key(4'd2, 1'b0, 3'd3, 3'd2);
      push(4'd0, 1'b1, 1'b0, 3'd3, 3'd2);
      idle(1'b0, 1'b0, 3'd2, 3'd0);
      key(4'd3, 1'b0, 3'd2, 3'd1);
      add(4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0);
      idle(1'b0, 1'b0, 3'd2, 3'd0);
      key(4'd9, 1'b0, 3'd2, 3'd1);
      add(4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1);
      idle(1'b0, 1'b0, 3'd1, 3'd0);
      code4(4'd9, 4'd8, 4'd7, 4'd6, 3'd1, 1'b1, 1'b0, 3'd3);
      key(4'd1, 1'b1, 3'd3, 3'd1);
      key(4'd2, 1'b1, 3'd3, 3'd2);
      key(4'd3, 1'b1, 3'd3, 3'd3);
      key(4'd4, 1'b1, 3'd3, 3'd4);
      add(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0);
      // T2: three wrong codes
      s4 = nrows;
      code4(4'd1, 4'd2, 4'd3, 4'd5, 3'd3, 1'b0, 1'b0, 3'd2);
      code4(4'd1, 4'd2, 4'd3, 4'd5, 3'd2, 1'b0, 1'b0, 3'd1);
      code4(4'd1, 4'd2, 4'd3, 4'd5, 3'd1, 1'b0, 1'b1, 3'd0);
      // T6 setup: program 5555 and unlock with it
      s5 = nrows;
      code4(4'd1, 4'd2, 4'd3, 4'd4, 3'd3, 1'b1, 1'b0, 3'd3);
      key(4'd5, 1'b1, 3'd3, 3'd1);
      key(4'd5, 1'b1, 3'd3, 3'd2);
      key(4'd5, 1'b1, 3'd3, 3'd3);
      key(4'd5, 1'b1, 3'd3, 3'd4);
      add(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0);
      code4(4'd5, 4'd5, 4'd5, 4'd5, 3'd3, 1'b1, 1'b0, 3'd3);
      s6 = nrows;
      code4(4'd1, 4'd2, 4'd3, 4'd5, 3'd3, 1'b0, 1'b0, 3'd2);
      code4(4'd1, 4'd2, 4'd3, 4'd5, 3'd2, 1'b0, 1'b0, 3'd1);
      code4(4'd1, 4'd2, 4'd3, 4'd5, 3'd1, 1'b0, 1'b1, 3'd0);
      // after reset 5555 is stale and 1234 is back
      s7 = nrows;
      code4(4'd5, 4'd5, 4'd5, 4'd5, 3'd3, 1'b0, 1'b0, 3'd2);
      code4(4'd1, 4'd2, 4'd3, 4'd4, 3'd2, 1'b1, 1'b0, 3'd3);

      reset_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      check("reset_access", 16'(access), 16'd0);
      check("reset_alarm", 16'(alarm), 16'd0);
      check("reset_locked_out", 16'(locked_out), 16'd0);
      check("reset_tries_left", 16'(tries_left), 16'd3);
      check("reset_digit_cnt", 16'(digit_cnt), 16'd0);
      reset_n = 1'b1;

      run("t1_unlock", s1, s2);
      n = 1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!access) break;
         n++;
      end
      check("t1_window_len", 16'(n), 16'd100);
      check("t1_tries_after", 16'(tries_left), 16'd3);

      run("t3_t4_prog", s2, s3);
      wait_access_low(300, ok);
      check("t4_window_ends", 16'(ok), 16'd1);

      run("t5_priority", s3, s4);
      wait_access_low(300, ok);

      run("t2_lockout", s4, s5);
      n = 1;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         digit = 4'(i % 10); digit_valid = 1'b1; enter = (i % 7 == 3);
         clear = (i % 11 == 5); prog_en = (i % 5 == 0);
         @(posedge clk);
         @(negedge clk);
         if (digit_cnt != 3'd0 || locked_out !== alarm) bad++;
         if (!alarm) break;
         n++;
      end
      drive_idle();
      check("t2_lockout_len", 16'(n), 16'd1000);
      check("t2_keys_ignored", 16'(bad), 16'd0);
      check("t2_tries_after", 16'(tries_left), 16'd3);
      check("t2_locked_out_after", 16'(locked_out), 16'd0);

      run("t6_unlock", s5, s6);
      async_reset();
      run("t6_lockout", s6, s7);
      async_reset();
      run("t6_pin_restored", s7, nrows);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
